// File: rtl/seg7_capture_decoder_pkg.sv
// ============================================================================
// Module : seg7_capture_decoder_pkg
// Brief  : Shared seven-segment glyph constants and capture FSM state type.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_capture_decoder_pkg;

  // Active-low g..a patterns. Element [v] is the glyph for hex value v
  // (concatenation lists F first, so index 0 lands in the low slot).
  localparam logic [15:0][6:0] GLYPH = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [6:0] SEG_BLANK   = 7'b1111111;
  localparam logic [6:0] ALT_GLYPH_7 = 7'b1011000;
  localparam logic [6:0] ALT_GLYPH_9 = 7'b0011000;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_glyph_lookup.sv
// ============================================================================
// Module : seg7_glyph_lookup
// Brief  : Combinational active-low segment pattern to hex value decoder.
//          Build option SEG7_ALT_GLYPH_EN also accepts alternate 7 and 9.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_glyph_lookup
  import seg7_capture_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic       blank,
  output logic [3:0] value
);

  always_comb begin
    hit   = 1'b0;
    value = 4'd0;
    blank = (pattern == SEG_BLANK);
    for (int v = 0; v < 16; v++) begin
      if (pattern == GLYPH[v]) begin
        hit   = 1'b1;
        value = 4'(v);
      end
    end
`ifdef SEG7_ALT_GLYPH_EN
    if (pattern == ALT_GLYPH_7) begin
      hit   = 1'b1;
      value = 4'd7;
    end
    if (pattern == ALT_GLYPH_9) begin
      hit   = 1'b1;
      value = 4'd9;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/seg7_capture_decoder.sv
// ============================================================================
// Module : seg7_capture_decoder
// Brief  : Snoops a multiplexed active-low 7-segment bus and recovers the hex
//          nibble per digit. Option macro: SEG7_ALT_GLYPH_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_capture_decoder
  import seg7_capture_decoder_pkg::*;
#(
  parameter  int NUM_DIGITS    = 4,
  parameter  int STABLE_CYCLES = 4,
  localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err,
  output logic [IDX_W-1:0]        err_digit
);

  logic [6:0]            seg_q, seg_prev;
  logic [NUM_DIGITS-1:0] an_q, an_prev;
  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [NUM_DIGITS-1:0] seen;
  logic                  sel_valid, changed, capture;
  logic [IDX_W-1:0]      sel_idx;
  logic                  hit, blank;
  logic [3:0]            value;

  // Two-deep sample history: current registered copy and the one before it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q    <= '1;
      an_q     <= '1;
      seg_prev <= '1;
      an_prev  <= '1;
    end else begin
      seg_q    <= seg_in;
      an_q     <= an_in;
      seg_prev <= seg_q;
      an_prev  <= an_q;
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) sel_idx = IDX_W'(i);
    end
  end

  assign sel_valid = $onehot(~an_q);
  assign changed   = (seg_q != seg_prev) || (an_q != an_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (!sel_valid) begin
      state_n = ST_WAIT;
      cnt_n   = '0;
    end else if (changed || state == ST_WAIT) begin
      cnt_n   = CNT_W'(1);
      state_n = (STABLE_CYCLES == 1) ? ST_LOCKED : ST_COUNT;
    end else if (state == ST_COUNT) begin
      cnt_n   = cnt + 1'b1;
      state_n = (cnt_n == CNT_W'(STABLE_CYCLES)) ? ST_LOCKED : ST_COUNT;
    end
  end

  // Capture fires on the edge where the run length first reaches STABLE_CYCLES.
  always_comb begin
    capture = 1'b0;
    if (sel_valid) begin
      if (changed || state == ST_WAIT)
        capture = (STABLE_CYCLES == 1);
      else if (state == ST_COUNT)
        capture = (cnt == CNT_W'(STABLE_CYCLES - 1));
    end
  end

  seg7_glyph_lookup u_lookup (
    .pattern (seg_q),
    .hit     (hit),
    .blank   (blank),
    .value   (value)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= '0;
      digit_valid <= '0;
      seen        <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      err_digit   <= '0;
    end else begin
      frame_done <= &seen;
      err        <= capture && !hit && !blank;
      if (capture && !hit && !blank) err_digit <= sel_idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        // A completed frame clears its mask; a capture now belongs to the next one.
        seen[i] <= ((&seen) ? 1'b0 : seen[i]) | (capture && sel_idx == IDX_W'(i));
        if (capture && sel_idx == IDX_W'(i)) begin
          digit_valid[i] <= hit;
          if (hit) digits[4*i +: 4] <= value;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_capture_decoder.sv
// ============================================================================
// Module : tb_seg7_capture_decoder
// Brief  : Randomized and directed bench against a run-length reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_capture_decoder;

  localparam int N = 4;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg_in;
  logic [N-1:0]  an_in;
  logic [4*N-1:0] digits;
  logic [N-1:0]  digit_valid;
  logic          frame_done;
  logic          err;
  logic [1:0]    err_digit;

  seg7_capture_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err         (err),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: a capture happens once per run of S identical valid samples.
  logic [3:0]    m_dig [N];
  logic [N-1:0]  m_valid, m_seen;
  logic          m_frame, m_err;
  logic [1:0]    m_errd;
  logic [10:0]   hist [$];
  int            frame_pulses;

  function automatic bit onehot_low(input logic [N-1:0] a);
    return $countones(~a) == 1;
  endfunction

  task automatic decode(input logic [6:0] p, output bit hit, output bit blank, output logic [3:0] val);
    hit = 0; val = 0;
    blank = (p == 7'h7F);
    for (int v = 0; v < 16; v++)
      if (p == glyph_tab[v]) begin hit = 1; val = 4'(v); end
`ifdef SEG7_ALT_GLYPH_EN
    if (p == 7'b1011000) begin hit = 1; val = 4'd7; end
    if (p == 7'b0011000) begin hit = 1; val = 4'd9; end
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_dig[i] = 0;
    m_valid = 0; m_seen = 0; m_frame = 0; m_err = 0; m_errd = 0;
    hist.delete();
  endtask

  task automatic model_step();
    int n;
    bit cap;
    bit hit, blank;
    logic [3:0] val;
    logic [10:0] s0;
    int idx;
    n = hist.size();
    cap = 0;
    idx = 0;
    s0 = '1;
    if (n >= S) begin
      s0  = hist[n-S];
      cap = onehot_low(s0[10:7]);
      for (int j = n-S+1; j < n; j++) if (hist[j] != s0) cap = 0;
      if (n-S-1 >= 0 && hist[n-S-1] == s0) cap = 0;
    end
    m_frame = (m_seen == '1);
    if (m_frame) m_seen = '0;
    m_err = 0;
    if (cap) begin
      for (int i = 0; i < N; i++) if (!s0[7+i]) idx = i;
      m_seen[idx] = 1'b1;
      decode(s0[6:0], hit, blank, val);
      m_valid[idx] = hit;
      if (hit) m_dig[idx] = val;
      else if (!blank) begin m_err = 1; m_errd = 2'(idx); end
    end
    hist.push_back({an_in, seg_in});
    if (hist.size() > S+1) void'(hist.pop_front());
  endtask

  task automatic check_outputs();
    logic [4*N-1:0] ed;
    for (int i = 0; i < N; i++) ed[4*i +: 4] = m_dig[i];
    check("digits", 32'(digits), 32'(ed));
    check("digit_valid", 32'(digit_valid), 32'(m_valid));
    check("frame_done", 32'(frame_done), 32'(m_frame));
    check("err", 32'(err), 32'(m_err));
    check("err_digit", 32'(err_digit), 32'(m_errd));
    if (frame_done) frame_pulses++;
  endtask

  task automatic cycle(input logic [N-1:0] an, input logic [6:0] seg);
    an_in  = an;
    seg_in = seg;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic hold(input logic [N-1:0] an, input logic [6:0] seg, input int len);
    for (int k = 0; k < len; k++) cycle(an, seg);
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'h0);
    check({tag, "_valid"}, 32'(digit_valid), 32'h0);
    check({tag, "_frame"}, 32'(frame_done), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_errdig"}, 32'(err_digit), 32'h0);
  endtask

  initial begin
    logic [N-1:0] an;
    logic [6:0]   seg;
    int           r;

    rst = 1'b1; an_in = '1; seg_in = '1;
    frame_pulses = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_zero("por");
    rst = 1'b0;

    // Scan 1,2,3,4 across digits 0..3.
    hold(4'b1110, glyph_tab[1], 6);
    hold(4'b1101, glyph_tab[2], 6);
    hold(4'b1011, glyph_tab[3], 6);
    frame_pulses = 0;
    hold(4'b0111, glyph_tab[4], 6);
    check("scan_digits", 32'(digits), 32'h4321);
    check("scan_valid", 32'(digit_valid), 32'hF);
    check("scan_frame_pulses", 32'(frame_pulses), 32'd1);

    // Digit 2 held too briefly to capture.
    hold(4'b1011, glyph_tab[5], 3);
    hold(4'b1110, glyph_tab[1], 6);
    check("short_hold_d2", 32'(digits[11:8]), 32'h3);

    // Blank then bad glyph on digit 1.
    hold(4'b1101, 7'b1111111, 6);
    check("blank_valid1", 32'(digit_valid[1]), 32'h0);
    hold(4'b1101, 7'b0110110, 6);
    check("bad_digit1_kept", 32'(digits[7:4]), 32'h2);
    check("bad_errdig", 32'(err_digit), 32'h1);

    // Invalid selects.
    hold(4'b1100, glyph_tab[8], 10);
    hold(4'b1111, glyph_tab[8], 10);

    // Alternate 9 on digit 0.
    hold(4'b1110, 7'b0011000, 6);
`ifdef SEG7_ALT_GLYPH_EN
    check("alt9_digit0", 32'(digits[3:0]), 32'h9);
`else
    check("alt9_errdig", 32'(err_digit), 32'h0);
    check("alt9_invalid", 32'(digit_valid[0]), 32'h0);
`endif

    // Reset in the middle of a count.
    hold(4'b1110, glyph_tab[6], 6);
    hold(4'b1110, glyph_tab[3], 2);
    rst = 1'b1;
    #1;
    check_reset_zero("mid");
    model_reset();
    #1 rst = 1'b0;
    hold(4'b1110, glyph_tab[3], 4);
    check("mid_no_early_cap", 32'(digit_valid[0]), 32'h0);
    cycle(4'b1110, glyph_tab[3]);
    check("mid_cap", 32'(digits[3:0]), 32'h3);

    // Randomized runs.
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      if (r < 8) an = ~(4'b1 << $urandom_range(0, N-1));
      else       an = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 6)       seg = glyph_tab[$urandom_range(0, 15)];
      else if (r == 6) seg = 7'h7F;
      else if (r == 7) seg = ($urandom_range(0, 1) != 0) ? 7'b1011000 : 7'b0011000;
      else             seg = 7'($urandom);
      hold(an, seg, $urandom_range(1, 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
